// File: rtl/prog_imem.sv
// Program instruction memory with a UART-fed loader.
// Fetches mem[pc] each cycle while idle. A load request streams bytes,
// MSB first, into consecutive words starting at load_base.
module prog_imem #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 12,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h6F0F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   remaining;
    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] word_asm;
    logic [DATA_W-1:0] word_next;
    logic [ADDR_W+1:0] end_addr;

    logic start_ok;
    logic take_byte;
    logic wr_en;
    logic done_nxt;
    logic err_nxt;
    logic drop_partial;
    logic fetch_en;

    assign busy = (state == LOAD);

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nxt    = state;
        start_ok     = 1'b0;
        take_byte    = 1'b0;
        wr_en        = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        drop_partial = 1'b0;
        word_next    = (word_asm << 8) | DATA_W'(rx_data);
        end_addr     = {2'b00, load_base} + {1'b0, load_len};

        case (state)
            IDLE: begin
                if (load_start) begin
                    if (end_addr > {2'b01, {ADDR_W{1'b0}}}) begin
                        err_nxt = 1'b1;
                    end else if (load_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        start_ok  = 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                // Abort takes priority over a byte arriving in the same cycle
                if (load_abort) begin
                    drop_partial = 1'b1;
                    state_nxt    = IDLE;
                end else if (rx_valid) begin
                    take_byte = 1'b1;
                    if (byte_cnt == CNT_W'(BYTES - 1)) begin
                        wr_en = 1'b1;
                        if (remaining == (ADDR_W + 1)'(1)) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Fetch only on edges that both start and end in IDLE, so instr is
        // NOP for the whole load and valid returns one cycle after busy falls
        fetch_en = (state == IDLE) && (state_nxt == IDLE);
    end

    // State, loader bookkeeping and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            wr_ptr      <= '0;
            remaining   <= '0;
            byte_cnt    <= '0;
            word_asm    <= '0;
        end else begin
            state     <= state_nxt;
            load_done <= done_nxt;
            load_err  <= err_nxt;

            if (fetch_en) begin
                instr       <= mem[pc];
                instr_valid <= 1'b1;
            end else begin
                instr       <= NOP_WORD;
                instr_valid <= 1'b0;
            end

            if (start_ok) begin
                wr_ptr    <= load_base;
                remaining <= load_len;
                byte_cnt  <= '0;
            end

            if (drop_partial) begin
                byte_cnt <= '0;
            end

            if (take_byte) begin
                word_asm <= word_next;
                if (wr_en) begin
                    byte_cnt  <= '0;
                    wr_ptr    <= wr_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    // Memory write port; contents are deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= word_next;
        end
    end

endmodule
